// File: rtl/ripple_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ripple_fetch_ctrl
// Description : Single-outstanding instruction fetch controller. Issues word
//               fetches to a bridge, buffers one instruction for decode,
//               handles redirects (with in-flight response kill) and a debug
//               halt that only takes effect at an instruction boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_en_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        mem_en_q, mem_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        halted_q, halted_d;
  logic [31:0] redir_pc;

  // Redirect targets are always word aligned.
  assign redir_pc = {redirect_pc_i[31:2], 2'b00};

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (redirect_i) pc_d = redir_pc;
        state_d = halt ? ST_HALT : ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_valid_i) begin
          if (kill_q || redirect_i) begin
            // Stale response: drop it and refetch from the (new) pc.
            kill_d = 1'b0;
            if (redirect_i) pc_d = redir_pc;
          end else begin
            inst_d       = mem_rdata_i;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = ST_HOLD;
          end
        end else if (redirect_i) begin
          // Bridge cannot abort, so remember to discard the pending word.
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          inst_valid_d = 1'b0;
          pc_d         = redir_pc;
          state_d      = ST_FETCH;
        end else if (inst_ready_i) begin
          inst_valid_d = 1'b0;
          state_d      = halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (redirect_i) pc_d = redir_pc;
        if (!halt) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    mem_en_d = (state_d == ST_FETCH);
    halted_d = (state_d == ST_HALT);
    // A new address is launched only when a request starts; otherwise the
    // outstanding address stays put until the bridge answers.
    if ((state_d == ST_FETCH) && ((state_q != ST_FETCH) || mem_valid_i))
      mem_addr_d = pc_d;
    else
      mem_addr_d = mem_addr_q;
  end

  // State and registered outputs with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      halted_q     <= halted_d;
    end
  end

  assign mem_en_o     = mem_en_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign halted_o     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_fetch_ctrl
// Description : Directed self-checking bench for ripple_fetch_ctrl. Expected
//               {pc, instruction} pairs are queued when a response is driven
//               and compared when decode takes the instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] mem_addr_o;
  logic        mem_en_o;
  logic        mem_valid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        halted_o;

  int          errors = 0;
  int          checks = 0;
  int          xfers  = 0;
  logic [63:0] exp_q[$];

  ripple_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_addr_o(mem_addr_o), .mem_en_o(mem_en_o),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; a transfer seen before the edge is scored first.
  task automatic tick();
    logic [63:0] e;
    if (inst_valid_o && inst_ready_i) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", {inst_pc_o, inst_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("xfer", {inst_pc_o, inst_o}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Hold a fetch for lat cycles checking the address, then answer it.
  task automatic fetch_resp(input logic [31:0] addr, input logic [31:0] data,
                            input int lat, input bit accept);
    for (int i = 0; i < lat; i++) begin
      chk("wait_en", {63'd0, mem_en_o}, 64'd1);
      chk("wait_addr", {32'd0, mem_addr_o}, {32'd0, addr});
      tick();
    end
    chk("resp_en", {63'd0, mem_en_o}, 64'd1);
    chk("resp_addr", {32'd0, mem_addr_o}, {32'd0, addr});
    mem_valid_i = 1'b1;
    mem_rdata_i = data;
    if (accept) exp_q.push_back({addr, data});
    tick();
    mem_valid_i = 1'b0;
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; halt = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    mem_valid_i = 1'b0; mem_rdata_i = 32'd0; inst_ready_i = 1'b1;
    tick(); tick();
    // Reset state
    chk("rst_en", {63'd0, mem_en_o}, 64'd0);
    chk("rst_addr", {32'd0, mem_addr_o}, 64'd0);
    chk("rst_ivalid", {63'd0, inst_valid_o}, 64'd0);
    chk("rst_inst", {32'd0, inst_o}, 64'd0);
    chk("rst_ipc", {32'd0, inst_pc_o}, 64'd0);
    chk("rst_halted", {63'd0, halted_o}, 64'd0);
    rst_n = 1'b1;
    tick();
    // Basic fetch with 2-cycle latency
    fetch_resp(32'h0, 32'h0000_0013, 2, 1'b1);
    chk("f0_ivalid", {63'd0, inst_valid_o}, 64'd1);
    chk("f0_inst", {32'd0, inst_o}, 64'h13);
    chk("f0_ipc", {32'd0, inst_pc_o}, 64'h0);
    chk("f0_hold_en", {63'd0, mem_en_o}, 64'd0);
    tick();
    chk("f0_next_en", {63'd0, mem_en_o}, 64'd1);
    chk("f0_next_addr", {32'd0, mem_addr_o}, 64'h4);
    chk("f0_ivalid_clr", {63'd0, inst_valid_o}, 64'd0);

    // Decode stall for 5 cycles
    inst_ready_i = 1'b0;
    fetch_resp(32'h4, 32'h0000_000A, 0, 1'b1);
    n0 = xfers;
    for (int i = 0; i < 5; i++) begin
      chk("stall_en", {63'd0, mem_en_o}, 64'd0);
      chk("stall_ivalid", {63'd0, inst_valid_o}, 64'd1);
      chk("stall_data", {inst_pc_o, inst_o}, {32'h4, 32'hA});
      tick();
    end
    inst_ready_i = 1'b1;
    tick();
    chk("stall_one_xfer", 64'(xfers - n0), 64'd1);
    chk("stall_ivalid_clr", {63'd0, inst_valid_o}, 64'd0);
    chk("stall_next_addr", {mem_en_o, 31'd0, mem_addr_o}, {1'b1, 31'd0, 32'h8});

    // Redirect while fetch at 0x8 pending
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    tick();
    redirect_i = 1'b0;
    chk("kill_ivalid0", {63'd0, inst_valid_o}, 64'd0);
    fetch_resp(32'h8, 32'hDEAD_BEEF, 2, 1'b0);
    chk("kill_ivalid1", {63'd0, inst_valid_o}, 64'd0);
    chk("kill_next", {mem_en_o, 31'd0, mem_addr_o}, {1'b1, 31'd0, 32'h100});
    fetch_resp(32'h100, 32'h0000_0011, 1, 1'b1);
    tick();

    // Redirect coincident with mem_valid
    chk("coin_addr", {32'd0, mem_addr_o}, 64'h104);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    mem_valid_i = 1'b1; mem_rdata_i = 32'hBAD0_0000;
    tick();
    redirect_i = 1'b0; mem_valid_i = 1'b0;
    chk("coin_ivalid", {63'd0, inst_valid_o}, 64'd0);
    chk("coin_next", {mem_en_o, 31'd0, mem_addr_o}, {1'b1, 31'd0, 32'h200});

    // Halt mid-fetch
    halt = 1'b1;
    tick();
    fetch_resp(32'h200, 32'h0000_0022, 0, 1'b1);
    chk("halt_hold_halted", {63'd0, halted_o}, 64'd0);
    chk("halt_hold_ivalid", {63'd0, inst_valid_o}, 64'd1);
    tick();
    chk("halt_halted", {63'd0, halted_o}, 64'd1);
    chk("halt_en", {63'd0, mem_en_o}, 64'd0);
    mem_valid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    tick();
    mem_valid_i = 1'b0;
    chk("halt_stray_ivalid", {63'd0, inst_valid_o}, 64'd0);
    chk("halt_still", {mem_en_o, halted_o}, 64'b01);
    halt = 1'b0;
    tick();
    chk("resume", {mem_en_o, halted_o, 30'd0, mem_addr_o}, {1'b1, 1'b0, 30'd0, 32'h204});

    // Wrap at top of address space (unaligned target forced to alignment)
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    fetch_resp(32'h204, 32'h1234_5678, 0, 1'b0);
    fetch_resp(32'hFFFF_FFFC, 32'h0000_0033, 0, 1'b1);
    tick();
    chk("wrap_addr", {mem_en_o, 31'd0, mem_addr_o}, {1'b1, 31'd0, 32'h0});

    // Redirect in HOLD with handshake in the same cycle
    inst_ready_i = 1'b0;
    fetch_resp(32'h0, 32'h0000_0044, 0, 1'b1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300; inst_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    chk("hredir_ivalid", {63'd0, inst_valid_o}, 64'd0);
    chk("hredir_next", {mem_en_o, 31'd0, mem_addr_o}, {1'b1, 31'd0, 32'h300});

    // Asynchronous reset mid-fetch, stray response after release
    rst_n = 1'b0;
    #1;
    chk("arst_en", {63'd0, mem_en_o}, 64'd0);
    chk("arst_addr", {32'd0, mem_addr_o}, 64'd0);
    tick();
    rst_n = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    tick();
    mem_valid_i = 1'b0;
    chk("arst_ivalid", {63'd0, inst_valid_o}, 64'd0);
    chk("arst_fetch", {mem_en_o, 31'd0, mem_addr_o}, {1'b1, 31'd0, 32'h0});
    tick();
    chk("arst_ivalid2", {63'd0, inst_valid_o}, 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
